// File: rtl/dm_arb_pkg.sv
// Shared encodings and default widths for the data-memory port arbiter.
package dm_arb_pkg;

  localparam int unsigned DM_ADDR_W     = 32;
  localparam int unsigned DM_DATA_W     = 32;
  localparam int unsigned DM_STARVE_MAX = 4;
  localparam int unsigned DM_CNT_W      = 4;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating count of consecutive denied DBG cycles; force_dbg_o flags that
// DBG must win the next arbitration.
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DM_STARVE_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dbg_req_i,
  input  logic dbg_gnt_i,
  output logic force_dbg_o
);

  logic [DM_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (dbg_req_i && !dbg_gnt_i) begin
      cnt_d = (cnt_q == DM_CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + DM_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_dbg_o = (cnt_q == DM_CNT_W'(STARVE_MAX));

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port data memory arbiter between the MEM stage (CPU) and a debug port.
// Optional debug lock (exclusive DBG ownership) enabled by DM_ARB_LOCK_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DM_ADDR_W,
  parameter int unsigned DATA_W     = DM_DATA_W,
  parameter int unsigned STARVE_MAX = DM_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_lock_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              cpu_locked_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  lock_state_e       state_q;
  logic              locked;
  logic              force_dbg;
  logic              dbg_win, cpu_win;
  logic              rd_pend_q, rd_owner_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

`ifdef DM_ARB_LOCK_EN
  lock_state_e state_d;

  always_comb begin
    state_d = ST_NORMAL;
    if (dbg_lock_i) state_d = ST_LOCKED;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_NORMAL;
    else       state_q <= state_d;
  end
`else
  logic unused_lock;
  assign unused_lock = dbg_lock_i;
  assign state_q     = ST_NORMAL;
`endif

  assign locked       = (state_q == ST_LOCKED);
  assign cpu_locked_o = locked;

  dm_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dbg_req_i   (dbg_req_i),
    .dbg_gnt_i   (dbg_gnt_o),
    .force_dbg_o (force_dbg)
  );

  // Grant and memory mux; everything is held quiet while reset is asserted.
  always_comb begin
    dbg_win     = dbg_req_i & (locked | ~cpu_req_i | force_dbg);
    cpu_win     = cpu_req_i & ~locked & ~dbg_win;
    dbg_gnt_o   = dbg_win & ~rst_i;
    cpu_gnt_o   = cpu_win & ~rst_i;
    cpu_stall_o = cpu_req_i & ~cpu_win & ~rst_i;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end else if (dbg_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWN_CPU;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      rd_pend_q  <= mem_en_o & ~mem_we_o;
      rd_owner_q <= dbg_gnt_o ? OWN_DBG : OWN_CPU;
      if (cpu_rvalid_o) cpu_rdata_q <= mem_rdata_i;
      if (dbg_rvalid_o) dbg_rdata_q <= mem_rdata_i;
    end
  end

  // Owner sees live memory data on its return cycle; the other port holds.
  assign cpu_rvalid_o = rd_pend_q & (rd_owner_q == OWN_CPU);
  assign dbg_rvalid_o = rd_pend_q & (rd_owner_q == OWN_DBG);
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
  assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : dbg_rdata_q;

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port) that preloads and inspects memory while the CPU runs. It sits between the MEM stage and the data memory instance. It issues at most one access per cycle and returns registered read data to the owning port. It stalls the pipeline while the CPU port is denied, and bounds debug starvation with a counter.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- STARVE_MAX, 4, denied DBG cycles before DBG is forced to win (1..15)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- cpu_req_i  in  1  CPU access request (MemRead|MemWrite of MEM stage)
- cpu_we_i  in  1  CPU write
- cpu_addr_i  in  ADDR_W  CPU address
- cpu_wdata_i  in  DATA_W  CPU write data
- cpu_gnt_o  out  1  CPU access issued this cycle
- cpu_stall_o  out  1  cpu_req_i & ~cpu_gnt_o; freezes PC and IF/ID..EX/MEM
- cpu_rvalid_o  out  1  CPU read data valid
- cpu_rdata_o  out  DATA_W  CPU read data
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/1/ADDR_W/DATA_W  DBG request fields
- dbg_lock_i  in  1  DBG requests exclusive memory ownership
- dbg_gnt_o, dbg_rvalid_o  out  1  DBG grant / read valid
- dbg_rdata_o  out  DATA_W  DBG read data
- cpu_locked_o  out  1  lock state active
- mem_en_o, mem_we_o  out  1  memory enable / write
- mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W
- mem_rdata_i  in  DATA_W  memory read data, valid one cycle after a read enable

## Operation
- Grant is combinational from the current requests and registered state. There is exactly one grant or none.
- Priority in NORMAL:
  - CPU wins when starve_cnt < STARVE_MAX.
  - DBG wins when starve_cnt == STARVE_MAX.
  - A lone requester always wins.
- mem_* is driven from the granted port. With no grant, mem_en_o=0, mem_we_o=0, and addr/wdata=0.
- starve_cnt (4 bit):
  - increments when dbg_req_i is high and not granted;
  - saturates at STARVE_MAX;
  - clears on a DBG grant or when dbg_req_i is low.
- Read return: on a granted read, rd_owner and rd_pend are registered. The next cycle, the owner's rvalid_o=1 and its rdata_o=mem_rdata_i. The other port's rdata_o holds its last value.
- Writes produce no rvalid.
- Lock state machine, states NORMAL and LOCKED:
  - NORMAL→LOCKED on a clock edge where dbg_lock_i=1.
  - LOCKED→NORMAL on an edge where dbg_lock_i=0.
  - In LOCKED, cpu_gnt_o=0 and DBG wins whenever it requests.
  - A read issued by the CPU in the last NORMAL cycle still returns its rvalid in the first LOCKED cycle.
- Simultaneous DBG force and CPU request: the CPU is stalled exactly one cycle, then the counter clears and the CPU regains priority.

## Timing
- Reset values: all outputs 0; starve_cnt=0; state NORMAL; rd_pend=0; rdata registers 0.
- Grant latency is 0 cycles (same cycle as the request). Read data latency is 1 cycle after grant. A write commits at the grant edge.
- Back-to-back granted reads from either port are allowed every cycle. rvalid tracks owners in order.
- Reset asserted mid-operation clears pending rvalid immediately (asynchronous). No rvalid is emitted after reset release for pre-reset reads.
- The request fields must stay stable while req_i is high and ungranted. The CPU stall guarantees this for the CPU port.

## Configuration
- DM_ARB_LOCK_EN defined: dbg_lock_i, cpu_locked_o and the NORMAL/LOCKED state machine are present as described.
- DM_ARB_LOCK_EN undefined:
  - the state register is removed and the arbiter behaves as permanently NORMAL;
  - dbg_lock_i is ignored;
  - cpu_locked_o is tied to 0.
- The port list is unchanged either way.

## Structure
- Shared package dm_arb_pkg:
  - owner encoding (OWN_CPU=1'b0, OWN_DBG=1'b1);
  - lock state encoding (ST_NORMAL, ST_LOCKED);
  - default widths.
- One natural sub-module, dm_arb_starve_cnt: the saturating starvation counter with a force-DBG output. Mux and return logic stay in the top.

## Test plan
- After reset, CPU-only read of addr 0x10 holding 0x0000_0007: cpu_gnt_o=1 in the same cycle; next cycle cpu_rvalid_o=1 with cpu_rdata_o=7; no stall.
- CPU and DBG both request continuously with STARVE_MAX=4: CPU granted for 4 cycles, DBG granted on the 5th with cpu_stall_o=1 for that cycle only; the pattern repeats.
- DBG write 0x0000_0055 to 0x20, then CPU read of 0x20 in the next cycle: cpu_rdata_o=0x55 one cycle after the CPU grant.
- With DM_ARB_LOCK_EN: raise dbg_lock_i while the CPU reads each cycle:
  - the next cycle cpu_locked_o=1 and cpu_gnt_o=0 with cpu_stall_o=1;
  - the in-flight CPU read's rvalid still appears;
  - after dbg_lock_i drops, the CPU is granted the next cycle.
- Assert rst_i for 1 cycle while a DBG read is granted: all outputs 0 immediately; no dbg_rvalid_o after release; starve_cnt=0.
- Without DM_ARB_LOCK_EN: hold dbg_lock_i=1 while the CPU and DBG request; the 4:1 fairness pattern is unchanged and cpu_locked_o stays 0.
